// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write-port arbiter: shares one FIFO write port among NUM_REQ producers with bounded bursts.
// Optional per-requester beat counters on stat_beats are built when ARB_STATS_EN is defined.
module fifo_rr_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_beats
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] next_ptr;
  logic            pick_found;
  logic            g_valid;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return ID_W'(sum);
  endfunction

  assign next_ptr = wrap_add(grant_id_q, 1);

  // Scan from the farthest offset down so the candidate nearest rr_ptr is the one left standing.
  always_comb begin : pick_logic
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr_q, 32'(k))]) begin
        pick       = wrap_add(rr_ptr_q, 32'(k));
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin : next_state_logic
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    req_ready   = '0;
    fifo_wr_en  = 1'b0;
    fifo_in     = '0;
    g_valid     = req_valid[grant_id_q];

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_id_d  = pick;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        // NOTE: reset is synchronous, so the handshake is masked combinationally to keep a beat from landing in the reset cycle.
        fifo_in               = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        req_ready[grant_id_q] = !fifo_full && !reset;
        fifo_wr_en            = g_valid && !fifo_full && !reset;
        if (!g_valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (fifo_wr_en) begin
          burst_cnt_d = burst_cnt_q + BC_W'(1);
          if (burst_cnt_q == BC_W'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : state_regs
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);

`ifdef ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];
  logic [15:0] stat_d [NUM_REQ];

  always_comb begin : stat_logic
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (fifo_wr_en && (grant_id_q == ID_W'(i)) && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
      stat_beats[i*16 +: 16] = stat_q[i];
    end
  end

  always_ff @(posedge clk) begin : stat_regs
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        stat_q[i] <= '0;
      end else begin
        stat_q[i] <= stat_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Scoreboard bench for fifo_rr_write_arbiter: directed producer traffic, a monitor checks every FIFO write in order.
// Define ARB_STATS_EN for both files to also check the beat counters.
module tb_fifo_rr_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic             fifo_full = 1'b0;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_in;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef ARB_STATS_EN
  logic [NR*16-1:0] stat_beats;
`endif

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mon_e;
  logic [DW-1:0] prod_q[NR][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic          wr_log  [128];
  logic          busy_log[128];
  logic [1:0]    gid_log [128];
  logic [NR-1:0] rdy_log [128];

  int         nb;
  logic [1:0] ord[8];
  int         len[8];

  fifo_rr_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_in    (fifo_in),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_beats (stat_beats)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int tag, input int id, input int k);
    return {8'(tag), 8'(id), 16'hBEEF, 32'(k)};
  endfunction

  task automatic load(input int id, input int first, input int n, input int tag);
    for (int k = first; k < first + n; k++) prod_q[id].push_back(mk(tag, id, k));
  endtask

  task automatic expect_beat(input int id, input int k, input int tag);
    exp_q.push_back({2'(id), mk(tag, id, k)});
  endtask

  // One clock: drive at negedge from producer queues, sample #1 later, retire accepted beats.
  task automatic cycle(input logic full, input logic rst);
    @(negedge clk);
    reset     = rst;
    fifo_full = full;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (prod_q[i].size() > 0);
      req_data[i*DW +: DW]  = req_valid[i] ? prod_q[i][0] : '0;
    end
    #1;
    wr_log[cyc]   = fifo_wr_en;
    busy_log[cyc] = busy;
    gid_log[cyc]  = grant_id;
    rdy_log[cyc]  = req_ready;
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) void'(prod_q[i].pop_front());
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cyc = 0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 200) begin
      cycle(1'b0, 1'b0);
      guard++;
    end
    cycle(1'b0, 1'b0);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] wr_pat(input int n);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < n; i++) p[i] = wr_log[i];
    return p;
  endfunction

  function automatic logic [31:0] busy_pat(input int n);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < n; i++) p[i] = busy_log[i];
    return p;
  endfunction

  // Monitor: every FIFO write must match the next expected beat and its requester.
  always @(negedge clk) begin
    #2;
    if (fifo_wr_en === 1'b1) begin
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_data", fifo_in, mon_e.data);
        check("wr_grant_id", 64'(grant_id), 64'(mon_e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, all valid low.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("rst_ready", 64'(rdy_log[1]), 64'd0);
    check("rst_wr_en", 64'(wr_log[1]), 64'd0);
    check("rst_grant_id", 64'(gid_log[1]), 64'd0);
    check("rst_busy", 64'(busy_log[1]), 64'd0);

    // Lone requester 2, six beats: 4 writes, bubble, 2 writes.
    cyc = 0;
    load(2, 0, 6, 2);
    for (int k = 0; k < 6; k++) expect_beat(2, k, 2);
    run(12);
    check("lone_wr_pattern", 64'(wr_pat(9)), 64'(9'b011011110));
    check("lone_busy_pattern", 64'(busy_pat(9)), 64'(9'b111011110));
    check("lone_grant_id", 64'(gid_log[1]), 64'd2);
    drain("lone");

    // All four requesters, eight beats each.
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 0, 8, 3);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        for (int k = 0; k < 4; k++) expect_beat(i, r*4 + k, 3);
    run(42);
    nb = 0;
    for (int b = 0; b < 8; b++) len[b] = 0;
    for (int c = 0; c < cyc; c++) begin
      if (busy_log[c] && (c == 0 || !busy_log[c-1])) begin
        if (nb < 8) ord[nb] = gid_log[c];
        nb++;
      end
      if (wr_log[c] && nb > 0 && nb <= 8) len[nb-1]++;
    end
    check("rr_num_bursts", 64'(nb), 64'd8);
    for (int b = 0; b < 8 && b < nb; b++) begin
      check("rr_grant_order", 64'(ord[b]), 64'(b % 4));
      check("rr_burst_len", 64'(len[b]), 64'd4);
    end
`ifdef ARB_STATS_EN
    for (int i = 0; i < NR; i++) check("stat_beats", 64'(stat_beats[i*16 +: 16]), 64'd8);
`endif
    drain("rr");

    // FIFO full for three cycles after the second beat.
    do_reset();
    load(0, 0, 6, 4);
    for (int k = 0; k < 6; k++) expect_beat(0, k, 4);
    for (int c = 0; c < 13; c++) cycle(c >= 3 && c <= 5, 1'b0);
    check("full_wr_pattern", 64'(wr_pat(9)), 64'(9'b011000110));
    for (int c = 3; c <= 5; c++) begin
      check("full_ready_low", 64'(rdy_log[c]), 64'd0);
      check("full_busy_held", 64'(busy_log[c]), 64'd1);
      check("full_grant_held", 64'(gid_log[c]), 64'd0);
    end
    check("full_burst_end", 64'(busy_log[8]), 64'd0);
    drain("full");

    // Requester 1 stops after two beats; requester 3 is next.
    do_reset();
    load(1, 0, 2, 5);
    load(3, 0, 2, 5);
    expect_beat(1, 0, 5);
    expect_beat(1, 1, 5);
    expect_beat(3, 0, 5);
    expect_beat(3, 1, 5);
    run(9);
    check("drop_wr_pattern", 64'(wr_pat(8)), 64'(8'b01100110));
    check("drop_first_grant", 64'(gid_log[1]), 64'd1);
    check("drop_busy_c3", 64'(busy_log[3]), 64'd1);
    check("drop_idle_c4", 64'(busy_log[4]), 64'd0);
    check("drop_next_grant", 64'(gid_log[5]), 64'd3);
    drain("drop");

    // Reset in the third beat cycle of requester 2 while rr_ptr points at 2.
    do_reset();
    load(1, 0, 1, 6);
    expect_beat(1, 0, 6);
    run(4);
    cyc = 0;
    load(2, 0, 4, 6);
    load(1, 1, 2, 6);
    expect_beat(2, 0, 6);
    expect_beat(2, 1, 6);
    expect_beat(1, 1, 6);
    expect_beat(1, 2, 6);
    expect_beat(2, 2, 6);
    expect_beat(2, 3, 6);
    run(3);
    cycle(1'b0, 1'b1);
    run(9);
    check("mrst_pre_grant", 64'(gid_log[1]), 64'd2);
    check("mrst_no_write", 64'(wr_log[3]), 64'd0);
    check("mrst_no_ready", 64'(rdy_log[3]), 64'd0);
    check("mrst_idle", 64'(busy_log[4]), 64'd0);
    check("mrst_grant_cleared", 64'(gid_log[4]), 64'd0);
    check("mrst_rr_cleared", 64'(gid_log[5]), 64'd1);
    check("mrst_regrant_busy", 64'(busy_log[5]), 64'd1);
    drain("mrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
